// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
    ALUWB, BRANCH, JAL, LUI, JALR1, JALR2, JALR3
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Branch condition from funct3; the reduced set keeps only beq.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu,
                                        input logic ext);
    logic t;
    t = 1'b0;
    if (!ext) begin
      t = (f3 == 3'b000) && zero;
    end else begin
      case (f3)
        3'b000:  t = zero;
        3'b001:  t = !zero;
        3'b100:  t = lt;
        3'b101:  t = !lt;
        3'b110:  t = ltu;
        3'b111:  t = !ltu;
        default: t = 1'b0;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction fields, flags and control strobes
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       Lt;
  logic       Ltu;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, Lt, Ltu,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, Lt, Ltu,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, Illegal
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - maps ALUOp and funct fields to the ALU operation
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the multicycle RV32I datapath
module multicycle_controller
  import mc_pkg::*;
#(
  parameter bit ENABLE_BRANCH_EXT = 1'b1,
  parameter bit ENABLE_LUI        = 1'b1,
  parameter bit ENABLE_JALR       = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master ctrl
);

  state_t     state_q, state_d, state_eff;
  logic       op_legal;
  logic       taken;
  logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src, alu_control;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    op_legal = 1'b0;
    case (ctrl.op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: op_legal = 1'b1;
      OP_LUI:  op_legal = ENABLE_LUI;
      OP_JALR: op_legal = ENABLE_JALR;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        if (!op_legal) begin
          state_d = FETCH;
        end else begin
          case (ctrl.op)
            OP_LOAD, OP_STORE: state_d = MEMADR;
            OP_RTYPE:          state_d = EXECUTER;
            OP_ITYPE:          state_d = EXECUTEI;
            OP_BRANCH:         state_d = BRANCH;
            OP_JAL:            state_d = JAL;
            OP_LUI:            state_d = LUI;
            OP_JALR:           state_d = JALR1;
            default:           state_d = FETCH;
          endcase
        end
      end
      MEMADR:   state_d = ctrl.op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      JALR1:    state_d = JALR2;
      JALR2:    state_d = JALR3;
      default:  state_d = FETCH;
    endcase
  end

  // Reset overrides the held state so outputs show the fetch decode immediately.
  assign state_eff = reset ? FETCH : state_q;

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    case (state_eff)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: reg_write = 1'b1;
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      BRANCH: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      LUI: begin
        result_src = RES_IMMEXT;
        reg_write  = 1'b1;
      end
      JALR1: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      // link write and target add share a cycle; A already holds rs1
      JALR2: begin
        reg_write = 1'b1;
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      JALR3:   pc_update = 1'b1;
      default: pc_update = 1'b0;
    endcase
  end

  always_comb begin
    imm_src = IMM_I;
    case (ctrl.op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      OP_LUI:    imm_src = ENABLE_LUI ? IMM_U : IMM_I;
      default:   imm_src = IMM_I;
    endcase
  end

  assign taken = branch_taken(ctrl.funct3, ctrl.Zero, ctrl.Lt, ctrl.Ltu, ENABLE_BRANCH_EXT);

  mc_alu_decoder u_alu_dec (
    .aluop      (alu_op),
    .funct3     (ctrl.funct3),
    .op5        (ctrl.op[5]),
    .funct7b5   (ctrl.funct7b5),
    .alucontrol (alu_control)
  );

  assign ctrl.PCWrite    = !reset && (pc_update || (branch && taken));
  assign ctrl.IRWrite    = !reset && ir_write;
  assign ctrl.MemWrite   = !reset && mem_write;
  assign ctrl.RegWrite   = !reset && reg_write;
  assign ctrl.Illegal    = !reset && (state_eff == DECODE) && !op_legal;
  assign ctrl.AdrSrc     = adr_src;
  assign ctrl.ResultSrc  = result_src;
  assign ctrl.ALUSrcA    = alu_src_a;
  assign ctrl.ALUSrcB    = alu_src_b;
  assign ctrl.ImmSrc     = imm_src;
  assign ctrl.ALUControl = alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench, full and reduced controller variants
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus_a ();
  multicycle_controller_if bus_b ();

  multicycle_controller #(.ENABLE_BRANCH_EXT(1'b1), .ENABLE_LUI(1'b1), .ENABLE_JALR(1'b1))
    dut_a (.clk(clk), .reset(reset), .ctrl(bus_a));
  multicycle_controller #(.ENABLE_BRANCH_EXT(1'b0), .ENABLE_LUI(1'b0), .ENABLE_JALR(1'b0))
    dut_b (.clk(clk), .reset(reset), .ctrl(bus_b));

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl, Illegal}
  logic [17:0] got_a, got_b, exp_a, exp_b;
  assign got_a = {bus_a.PCWrite, bus_a.AdrSrc, bus_a.MemWrite, bus_a.IRWrite, bus_a.ResultSrc,
                  bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ImmSrc, bus_a.RegWrite, bus_a.ALUControl,
                  bus_a.Illegal};
  assign got_b = {bus_b.PCWrite, bus_b.AdrSrc, bus_b.MemWrite, bus_b.IRWrite, bus_b.ResultSrc,
                  bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ImmSrc, bus_b.RegWrite, bus_b.ALUControl,
                  bus_b.Illegal};

  localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_R = 3, C_I = 4, C_BR = 5, C_JAL = 6,
                 C_LUI = 7, C_JALR = 8;

  function automatic int classify(input logic [6:0] op, input bit lui_en, input bit jalr_en);
    case (op)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b0110111: return lui_en ? C_LUI : C_ILL;
      7'b1100111: return jalr_en ? C_JALR : C_ILL;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic int cyc_len(input int c);
    case (c)
      C_LW, C_JALR:             return 5;
      C_SW, C_R, C_I, C_JAL:    return 4;
      C_BR, C_LUI:              return 3;
      default:                  return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic op5, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b011:  return 3'd6;
      3'b100:  return 3'd4;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit br_taken(input bit ext, input logic [2:0] f3, input logic z,
                                  input logic lt, input logic ltu);
    if (!ext) return (f3 == 3'b000) && z;
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs for step k of an instruction (k=0 is the fetch cycle).
  function automatic logic [17:0] model(input bit ext, input bit lui_en, input bit jalr_en,
                                        input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                        input logic z, input logic lt, input logic ltu,
                                        input int k_in, input bit rst);
    int c, k;
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb;
    logic [2:0] imm, alu;
    c = classify(op, lui_en, jalr_en);
    k = rst ? 0 : k_in;
    {pcw, adr, mw, irw, rw, ill} = 6'b0;
    res = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
    case (c)
      C_SW:    imm = 3'd1;
      C_BR:    imm = 3'd2;
      C_JAL:   imm = 3'd3;
      C_LUI:   imm = 3'd4;
      default: imm = 3'd0;
    endcase
    if (k == 0) begin
      irw = 1'b1; sb = 2'd2; res = 2'd2; pcw = 1'b1;
    end else if (k == 1) begin
      sa = 2'd1; sb = 2'd1; ill = (c == C_ILL);
    end else begin
      case (c)
        C_LW: begin
          if (k == 2) begin sa = 2'd2; sb = 2'd1; end
          else if (k == 3) adr = 1'b1;
          else begin res = 2'd1; rw = 1'b1; end
        end
        C_SW: begin
          if (k == 2) begin sa = 2'd2; sb = 2'd1; end
          else begin adr = 1'b1; mw = 1'b1; end
        end
        C_R, C_I: begin
          if (k == 2) begin
            sa = 2'd2; sb = (c == C_I) ? 2'd1 : 2'd0; alu = funct_alu(op[5], f3, f7);
          end else rw = 1'b1;
        end
        C_BR: begin
          sa = 2'd2; alu = 3'd1; pcw = br_taken(ext, f3, z, lt, ltu);
        end
        C_JAL: begin
          if (k == 2) begin sa = 2'd1; sb = 2'd2; pcw = 1'b1; end
          else rw = 1'b1;
        end
        C_LUI: begin res = 2'd3; rw = 1'b1; end
        C_JALR: begin
          if (k == 2) begin sa = 2'd1; sb = 2'd2; end
          else if (k == 3) begin rw = 1'b1; sa = 2'd2; sb = 2'd1; end
          else pcw = 1'b1;
        end
        default: ill = 1'b0;
      endcase
    end
    if (rst) {pcw, irw, mw, rw, ill} = 5'b0;
    return {pcw, adr, mw, irw, res, sa, sb, imm, rw, alu, ill};
  endfunction

  typedef struct {
    string       name;
    logic [17:0] got;
    logic [17:0] want;
  } pin_t;
  pin_t pins[$];

  int checks = 0;
  int errors = 0;
  int cur_k = 15;
  bit chk_on = 1'b0;
  logic [17:0] log_a[16];
  logic [17:0] log_b[16];

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (got_a !== exp_a) begin
        errors++;
        $display("FAIL model_a step=%0d got=%b exp=%b", cur_k, got_a, exp_a);
      end
      checks++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL model_b step=%0d got=%b exp=%b", cur_k, got_b, exp_b);
      end
      log_a[cur_k] = got_a;
      log_b[cur_k] = got_b;
    end
    while (pins.size() > 0) begin
      pin_t p;
      p = pins.pop_front();
      checks++;
      if (p.got !== p.want) begin
        errors++;
        $display("FAIL %s got=%0h exp=%0h", p.name, p.got, p.want);
      end
    end
  end

  task automatic pin(input string n, input logic [17:0] g, input logic [17:0] w);
    pins.push_back('{n, g, w});
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic lt, input logic ltu);
    bus_a.op = op; bus_a.funct3 = f3; bus_a.funct7b5 = f7;
    bus_a.Zero = z; bus_a.Lt = lt; bus_a.Ltu = ltu;
    bus_b.op = op; bus_b.funct3 = f3; bus_b.funct7b5 = f7;
    bus_b.Zero = z; bus_b.Lt = lt; bus_b.Ltu = ltu;
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input logic lt, input logic ltu,
                     input int ncyc, input int nrst, input int rst_at);
    int kk, la, lb;
    la = cyc_len(classify(op, 1'b1, 1'b1));
    lb = cyc_len(classify(op, 1'b0, 1'b0));
    for (int r = 0; r < nrst; r++) begin
      @(posedge clk); #1;
      drive(op, f3, f7, z, lt, ltu);
      reset = 1'b1;
      cur_k = 15;
      exp_a = model(1'b1, 1'b1, 1'b1, op, f3, f7, z, lt, ltu, 0, 1'b1);
      exp_b = model(1'b0, 1'b0, 1'b0, op, f3, f7, z, lt, ltu, 0, 1'b1);
      chk_on = 1'b1;
    end
    kk = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      drive(op, f3, f7, z, lt, ltu);
      cur_k = k;
      if (k == rst_at) begin
        reset = 1'b1;
        exp_a = model(1'b1, 1'b1, 1'b1, op, f3, f7, z, lt, ltu, 0, 1'b1);
        exp_b = model(1'b0, 1'b0, 1'b0, op, f3, f7, z, lt, ltu, 0, 1'b1);
        kk = 0;
      end else begin
        reset = 1'b0;
        exp_a = model(1'b1, 1'b1, 1'b1, op, f3, f7, z, lt, ltu, kk % la, 1'b0);
        exp_b = model(1'b0, 1'b0, 1'b0, op, f3, f7, z, lt, ltu, kk % lb, 1'b0);
        kk++;
      end
    end
    @(negedge clk); #1;
  endtask

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                         BR = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, JR = 7'b1100111,
                         FENCE = 7'b0001111;

  initial begin
    reset = 1'b1;
    drive(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_a = '0;
    exp_b = '0;

    run(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 6, 2, -1);
    pin("reset_vec", log_a[15], {4'b0000, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 3'b000, 1'b0});
    pin("lw_wb_resultsrc", 18'(log_a[4][13:12]), 18'd1);
    pin("lw_wb_regwrite", 18'(log_a[4][4]), 18'd1);
    pin("lw_regwrite_count", 18'(log_a[0][4] + log_a[1][4] + log_a[2][4] + log_a[3][4] + log_a[4][4]), 18'd1);
    pin("lw_no_memwrite", 18'(log_a[0][15] | log_a[1][15] | log_a[2][15] | log_a[3][15] | log_a[4][15]), 18'd0);
    pin("lw_refetch", 18'(log_a[5][14]), 18'd1);

    run(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    pin("sw_memwrite", 18'(log_a[3][15]), 18'd1);
    run(RT, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    pin("add_alucontrol", 18'(log_a[2][3:1]), 18'd0);
    pin("add_wb_regwrite", 18'(log_a[3][4]), 18'd1);
    run(RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    pin("sub_alucontrol", 18'(log_a[2][3:1]), 18'd1);
    run(IT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    pin("addi_f7_ignored", 18'(log_a[2][3:1]), 18'd0);
    run(RT, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    run(RT, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    run(IT, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    run(IT, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    run(RT, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    pin("and_alucontrol", 18'(log_a[2][3:1]), 18'd2);
    run(RT, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, -1);

    run(BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1, -1);
    pin("beq_taken_b", 18'(log_b[2][17]), 18'd1);
    run(BR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, -1);
    run(BR, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, -1);
    pin("bne_taken", 18'(log_a[2][17]), 18'd1);
    pin("bne_reduced_not_taken", 18'(log_b[2][17]), 18'd0);
    run(BR, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1, -1);
    pin("bne_not_taken", 18'(log_a[2][17]), 18'd0);
    run(BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1, -1);
    run(BR, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1, -1);
    run(BR, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1, -1);
    pin("bltu_taken", 18'(log_a[2][17]), 18'd1);
    pin("bltu_reduced_not_taken", 18'(log_b[2][17]), 18'd0);
    run(BR, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, -1);
    run(BR, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 4, 1, -1);
    pin("f3_010_never", 18'(log_a[2][17]), 18'd0);

    run(JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, -1);
    run(JR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 6, 1, -1);
    pin("jalr2_regwrite", 18'(log_a[3][4]), 18'd1);
    pin("jalr2_resultsrc", 18'(log_a[3][13:12]), 18'd0);
    pin("jalr3_pcwrite", 18'(log_a[4][17]), 18'd1);
    pin("jalr_refetch", 18'(log_a[5][14]), 18'd1);
    pin("jalr_disabled_illegal", 18'(log_b[1][0]), 18'd1);

    run(LU, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, -1);
    pin("lui_result", 18'(log_a[2][13:12]), 18'd3);
    pin("lui_disabled_illegal", 18'(log_b[1][0]), 18'd1);
    pin("lui_disabled_refetch", 18'(log_b[2][14]), 18'd1);

    run(FENCE, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1, -1);
    pin("illegal_pulse", 18'(log_a[1][0]), 18'd1);
    pin("illegal_one_cycle", 18'(log_a[2][0]), 18'd0);
    pin("illegal_refetch", 18'(log_a[2][14]), 18'd1);
    pin("illegal_no_regwrite", 18'(log_a[0][4] | log_a[1][4] | log_a[2][4]), 18'd0);

    run(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, 2);
    pin("sw_abort_no_memwrite", 18'(log_a[0][15] | log_a[1][15] | log_a[2][15] | log_a[3][15] | log_a[4][15]), 18'd0);
    pin("sw_abort_refetch", 18'(log_a[3][14]), 18'd1);
    run(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, 3);
    pin("sw_reset_in_memwrite", 18'(log_a[3][15]), 18'd0);

    run(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 6, 1, -1);

    chk_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
